// File: rtl/key_if.sv
// Key conditioner port bundle: raw active-low keys in, debounced level and event pulses out.
interface key_if #(parameter int NUM_KEYS = 3);
  logic [NUM_KEYS-1:0] key_n;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_KEYS-1:0] key_long;
  logic [NUM_KEYS-1:0] led;

  modport master (output key_n, input key_level, key_press, key_release, key_long, led);
  modport slave  (input key_n, output key_level, key_press, key_release, key_long, led);
endinterface

// File: rtl/key_conditioner.sv
// Per-key synchroniser + debounce FSM with registered press/release/long pulses.
// Long-press detection is built only when KEY_LONG_PRESS_EN is defined.
module key_chan #(
  parameter int DELAY_TIME = 1000000,
  parameter int LONG_TIME  = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic press,
  output logic rel,
  output logic long_p
);
  localparam int CW = $clog2(DELAY_TIME);
  localparam logic [CW-1:0] D_LAST = CW'(DELAY_TIME - 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  state_t        state;
  logic          s1, s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      state <= IDLE;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      s1    <= key_n;
      s2    <= s1;
      press <= 1'b0;
      rel   <= 1'b0;
      case (state)
        IDLE:
          if (!s2) begin state <= PRESS_WAIT; cnt <= '0; end
        PRESS_WAIT:
          if (s2) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == D_LAST) begin
            state <= HELD;
            cnt   <= '0;
            press <= 1'b1;
            level <= 1'b1;
          end else cnt <= cnt + 1'b1;
        HELD:
          if (s2) begin state <= RELEASE_WAIT; cnt <= '0; end
        RELEASE_WAIT:
          // a low sample here is release bounce: back to HELD silently
          if (!s2) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == D_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            rel   <= 1'b1;
            level <= 1'b0;
          end else cnt <= cnt + 1'b1;
        default: begin state <= IDLE; cnt <= '0; end
      endcase
    end
  end

`ifdef KEY_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_TIME);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_TIME - 1);

  logic [HW-1:0] hcnt;
  logic          fired;
  logic          rel_now;

  // long must not coincide with the release pulse on the same key
  assign rel_now = (state == RELEASE_WAIT) && s2 && (cnt == D_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hcnt   <= '0;
      fired  <= 1'b0;
      long_p <= 1'b0;
    end else begin
      long_p <= 1'b0;
      case (state)
        HELD, RELEASE_WAIT:
          if (state == RELEASE_WAIT && !s2) hcnt <= '0;
          else begin
            if (hcnt == H_LAST && !fired && !rel_now) begin
              long_p <= 1'b1;
              fired  <= 1'b1;
            end
            if (hcnt != H_LAST) hcnt <= hcnt + 1'b1;
          end
        PRESS_WAIT: hcnt <= '0;
        default: begin hcnt <= '0; fired <= 1'b0; end
      endcase
    end
  end
`else
  assign long_p = 1'b0;
`endif
endmodule

module key_conditioner #(
  parameter int DELAY_TIME = 1000000,
  parameter int LONG_TIME  = 50000000,
  parameter int NUM_KEYS   = 3
) (
  input logic  clk,
  input logic  rst_n,
  key_if.slave kif
);
  logic [NUM_KEYS-1:0] level, press, rel, long_p;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_chan #(.DELAY_TIME(DELAY_TIME), .LONG_TIME(LONG_TIME)) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .key_n  (kif.key_n[i]),
      .level  (level[i]),
      .press  (press[i]),
      .rel    (rel[i]),
      .long_p (long_p[i])
    );
  end

  assign kif.key_level   = level;
  assign kif.led         = level;
  assign kif.key_press   = press;
  assign kif.key_release = rel;
  assign kif.key_long    = long_p;
endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios then random key activity against a run-length model.
module tb_key_conditioner;
  localparam int D = 4;
  localparam int L = 12;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  key_if #(.NUM_KEYS(N)) kif();

  key_conditioner #(.DELAY_TIME(D), .LONG_TIME(L), .NUM_KEYS(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  logic [N-1:0] s1m, s2m, lvl_m, press_m, rel_m, long_m;
  int run [N], age [N];
  bit fired [N];
  int press_cnt [N], rel_cnt [N], long_cnt [N];
  int last_press [N], last_rel [N], last_long [N];
  bit all_seen;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%b exp=%b cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  // A key flips its debounced level once D+1 consecutive synchronised samples disagree with it.
  task automatic model_edge();
    press_m = '0; rel_m = '0; long_m = '0;
    if (!rst_n) begin
      s1m = '1; s2m = '1; lvl_m = '0;
      for (int i = 0; i < N; i++) begin run[i] = 0; age[i] = 0; fired[i] = 0; end
      return;
    end
    for (int i = 0; i < N; i++) begin
      bit pressed;
      int prev_run;
      pressed  = ~s2m[i];
      prev_run = run[i];
      if (pressed != lvl_m[i]) run[i]++; else run[i] = 0;
      if (run[i] == D + 1) begin
        run[i]   = 0;
        lvl_m[i] = pressed;
        if (pressed) begin press_m[i] = 1'b1; age[i] = 0; end
        else begin rel_m[i] = 1'b1; fired[i] = 0; end
      end else if (lvl_m[i]) begin
        if (prev_run > 0 && pressed) age[i] = 0;
        else begin
`ifdef KEY_LONG_PRESS_EN
          if (age[i] == L - 1 && !fired[i]) begin long_m[i] = 1'b1; fired[i] = 1; end
`endif
          if (age[i] < L - 1) age[i]++;
        end
      end
    end
    s2m = s1m;
    s1m = kif.key_n;
  endtask

  task automatic step(input logic [N-1:0] kn, input logic r);
    kif.key_n = kn;
    rst_n = r;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    chk("level", kif.key_level, lvl_m);
    chk("led", kif.led, lvl_m);
    chk("press", kif.key_press, press_m);
    chk("release", kif.key_release, rel_m);
    chk("long", kif.key_long, long_m);
    if (kif.key_press === 3'b111) all_seen = 1;
    for (int i = 0; i < N; i++) begin
      if (kif.key_press[i] === 1'b1) begin press_cnt[i]++; last_press[i] = cyc; end
      if (kif.key_release[i] === 1'b1) begin rel_cnt[i]++; last_rel[i] = cyc; end
      if (kif.key_long[i] === 1'b1) begin long_cnt[i]++; last_long[i] = cyc; end
    end
  endtask

  initial begin
    int k, p0, r0, l0;
    int rem [N];
    logic [N-1:0] kn;
    kif.key_n = '1;
    all_seen = 0;
    for (int i = 0; i < N; i++) begin
      press_cnt[i] = 0; rel_cnt[i] = 0; long_cnt[i] = 0;
      last_press[i] = 0; last_rel[i] = 0; last_long[i] = 0; rem[i] = 0;
    end

    // reset
    repeat (2) step(3'b111, 1'b0);
    chk("rst_outs", kif.key_press | kif.key_release | kif.key_level | kif.key_long, 3'b000);
    repeat (3) step(3'b111, 1'b1);

    // clean press on key 1
    k = cyc + 1; p0 = press_cnt[1];
    repeat (20) step(3'b101, 1'b1);
    chki("clean_press_cnt", press_cnt[1] - p0, 1);
    chki("clean_press_lat", last_press[1] - k, D + 2);
    k = cyc + 1; r0 = rel_cnt[1];
    repeat (10) step(3'b111, 1'b1);
    chki("clean_rel_cnt", rel_cnt[1] - r0, 1);
    chki("clean_rel_lat", last_rel[1] - k, D + 2);

    // press bounce on key 0
    p0 = press_cnt[0];
    repeat (3) step(3'b110, 1'b1);
    step(3'b111, 1'b1);
    repeat (3) step(3'b110, 1'b1);
    repeat (8) step(3'b111, 1'b1);
    chki("bounce_no_press", press_cnt[0] - p0, 0);
    repeat (10) step(3'b110, 1'b1);
    chki("bounce_final_press", press_cnt[0] - p0, 1);
    repeat (10) step(3'b111, 1'b1);

    // release bounce on key 2
    p0 = press_cnt[2]; r0 = rel_cnt[2];
    repeat (10) step(3'b011, 1'b1);
    repeat (2) step(3'b111, 1'b1);
    repeat (10) step(3'b011, 1'b1);
    chki("relb_press_cnt", press_cnt[2] - p0, 1);
    chki("relb_no_release", rel_cnt[2] - r0, 0);
    chk("relb_level", kif.key_level, 3'b100);
    repeat (10) step(3'b111, 1'b1);
    chki("relb_final_rel", rel_cnt[2] - r0, 1);

    // simultaneous keys
    all_seen = 0;
    repeat (10) step(3'b000, 1'b1);
    chki("simul_press", int'(all_seen), 1);
    repeat (10) step(3'b111, 1'b1);

    // long press on key 1
    l0 = long_cnt[1];
    repeat (40) step(3'b101, 1'b1);
`ifdef KEY_LONG_PRESS_EN
    chki("long_cnt", long_cnt[1] - l0, 1);
    chki("long_lat", last_long[1] - last_press[1], L);
`else
    chki("long_cnt", long_cnt[1] - l0, 0);
`endif
    repeat (10) step(3'b111, 1'b1);

    // reset mid-hold, key still held afterwards gives a fresh press
    p0 = press_cnt[1]; r0 = rel_cnt[1]; l0 = long_cnt[1];
    repeat (10) step(3'b101, 1'b1);
    repeat (2) step(3'b101, 1'b0);
    repeat (10) step(3'b101, 1'b1);
    chki("rstmid_press", press_cnt[1] - p0, 2);
    chki("rstmid_no_rel", rel_cnt[1] - r0, 0);
    chki("rstmid_no_long", long_cnt[1] - l0, 0);
    repeat (10) step(3'b111, 1'b1);

    // random key activity with occasional long holds and resets
    kn = '1;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0) begin
          kn[i] = 1'($urandom_range(0, 1));
          rem[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(15, 30))
                                               : int'($urandom_range(1, 8));
        end
        rem[i]--;
      end
      step(kn, ($urandom_range(0, 299) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_conditioner.md
# key_conditioner

Front-end key conditioning stage for the stopwatch datapath on the DE1-SOC board. It synchronises the three active-low push-buttons (reset, start/pause, display freeze), debounces each one independently and emits clean single-cycle press/release pulses plus a debounced level. The stopwatch control logic consumes `key_press` directly instead of running its own per-key debounce counters.

## Interface
- `DELAY_TIME`, 1000000: debounce window in clk cycles (20 ms at 50 MHz); must be ≥ 2.
- `LONG_TIME`, 50000000: hold time in clk cycles for a long-press event (1 s); must be > `DELAY_TIME`.
- `clk`  in  1  50 MHz board clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `key_n`  in  3  raw keys, 0 = pressed. Bit 0 is reset, bit 1 is start/pause, bit 2 is display.
- `key_level`  out  3  debounced level, 1 = key held (states HELD and RELEASE_WAIT).
- `key_press`  out  3  one-cycle pulse per debounced press.
- `key_release`  out  3  one-cycle pulse per debounced release.
- `key_long`  out  3  one-cycle pulse when a hold reaches `LONG_TIME`. Exists only when the long-press feature is compiled in (see Configuration).
- `led`  out  3  equals `key_level`, for the board LED indicators.

## Operation
- Per key:
  - 2-FF synchroniser `s1`→`s2`, both reset to 1 (released).
  - Debounce counter `cnt`, width `$clog2(DELAY_TIME)`.
  - 4-state FSM.
- Key channels are fully independent. Simultaneous events on different keys each produce their own pulses in the same cycle.
- FSM transitions, evaluated on `s2`:
  - IDLE: `s2`=0 → PRESS_WAIT, `cnt`←0. Otherwise stay.
  - PRESS_WAIT:
    - `s2`=1 → IDLE (bounce rejected, no pulse).
    - Else if `cnt`==`DELAY_TIME`-1 → HELD, `key_press`←1.
    - Else `cnt`++.
  - HELD: `s2`=1 → RELEASE_WAIT, `cnt`←0. Otherwise stay.
  - RELEASE_WAIT:
    - `s2`=0 → HELD (release bounce; no new press, no release).
    - Else if `cnt`==`DELAY_TIME`-1 → IDLE, `key_release`←1.
    - Else `cnt`++.
- Every pulse output is registered and high for exactly one cycle. Pulses on a single key are strictly ordered press → (long) → release and never overlap.
- Counters never wrap. `cnt` is cleared on every state entry, and its terminal compare is exact.
- Reset: all FSMs go to IDLE, all counters to 0, `s1`/`s2` to 1. Every output is 0 in the cycle after the reset edge.
- Reset mid-operation aborts any pending pulse. A key still held when `rst_n` deasserts is treated as a fresh press and produces `key_press` after the full debounce window.

## Timing
- Let edge k be the first clk edge at which `s1` samples `key_n`=0 and the key then stays low. `key_press` is high for the cycle following edge k+`DELAY_TIME`+2.
- `key_level` rises on the same edge as `key_press`. `key_release` and the fall of `key_level` follow the same latency, measured from the first edge that samples `key_n`=1.
- A low glitch shorter than `DELAY_TIME` consecutive `s2` samples produces no output activity.
- Throughput: at most one press per key per 2·`DELAY_TIME`+2 cycles.

## Configuration
- `KEY_LONG_PRESS_EN` defined:
  - A per-key hold counter (width `$clog2(LONG_TIME)`) clears on entry to HELD.
  - It increments in HELD and RELEASE_WAIT and saturates.
  - `key_long` pulses once, on the edge where the counter equals `LONG_TIME`-1 while the key is held.
  - At most one `key_long` per hold; it is re-armed only by passing through IDLE.
- `KEY_LONG_PRESS_EN` undefined: no hold counter is built, and `key_long` is driven constant 3'b000. All other behaviour is identical.

## Test plan
All scenarios use `DELAY_TIME`=4 and `LONG_TIME`=12.
- Reset: `rst_n`=0 for 2 cycles with `key_n`=3'b111 → all outputs 0; all FSMs in IDLE after release.
- Clean press: `key_n[1]` low from edge k, held 20 cycles, then high → `key_press`=3'b010 for one cycle after edge k+6; `key_level[1]`=1 from then; `key_release[1]` pulses 6 edges after the release is first sampled.
- Bounce: `key_n[0]` toggled low 3 cycles, high 1, low 3, high → no press, no level change; a final 10-cycle low → exactly one `key_press[0]`.
- Release bounce: while HELD, `key_n[2]` goes high 2 cycles then low → no `key_release`, no second `key_press`, `key_level[2]` stays 1.
- Simultaneous keys: all keys fall on the same edge → `key_press`=3'b111 in a single cycle.
- Long press:
  - With `KEY_LONG_PRESS_EN`, holding `key_n[1]` 40 cycles → one `key_long[1]` pulse 12 cycles after `key_press[1]`, no repeat.
  - Without the macro, `key_long` stays 0.
  - Reset asserted mid-hold → no `key_long` and no `key_release`.
